// File: rtl/adaptive_mode_sequencer.sv
// rtl/adaptive_mode_sequencer.sv - control-unit mode sequencer with drain/swap handshake, dwell and auto policy
//
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   valid          fetch activity sample
//   req_valid      manual mode-change request; req_mode is the target
//   auto_en        enable the windowed activity policy
//   req_ready      request accepted this cycle (combinational)
//   active_mode    current mode index; mode_onehot is its decode (combinational)
//   issue_stall    fetch must not issue; switching marks DRAIN/SWAP
//   switch_done    pulse on first RUN cycle after a switch
//   req_err        pulse after an out-of-range request was dropped
//   switch_count   completed switches, saturating
module adaptive_mode_sequencer #(
    parameter int NUM_MODES    = 4,
    parameter int RESET_MODE   = 0,
    parameter int DRAIN_CYCLES = 3,
    parameter int MIN_DWELL    = 16,
    parameter int WIN_LEN      = 64,
    parameter int UP_THRESH    = 48,
    parameter int DOWN_THRESH  = 8,
    parameter int CNT_W        = 16,
    localparam int MODE_W      = (NUM_MODES > 2) ? $clog2(NUM_MODES) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid,
    input  logic                 req_valid,
    input  logic [MODE_W-1:0]    req_mode,
    input  logic                 auto_en,
    output logic                 req_ready,
    output logic [MODE_W-1:0]    active_mode,
    output logic [NUM_MODES-1:0] mode_onehot,
    output logic                 issue_stall,
    output logic                 switching,
    output logic                 switch_done,
    output logic                 req_err,
    output logic [CNT_W-1:0]     switch_count
);

    localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int DWL_W = (MIN_DWELL > 0) ? $clog2(MIN_DWELL + 1) : 1;
    localparam int WIN_W = $clog2(WIN_LEN);
    localparam int ACT_W = $clog2(WIN_LEN + 1);

    localparam logic [MODE_W-1:0] TOP_MODE   = MODE_W'(NUM_MODES - 1);
    localparam logic [MODE_W-1:0] RST_MODE   = MODE_W'(RESET_MODE);
    localparam logic [MODE_W:0]   MODE_LIMIT = (MODE_W + 1)'(NUM_MODES);
    localparam logic [DRN_W-1:0]  DRN_LOAD   = DRN_W'(DRAIN_CYCLES - 1);
    localparam logic [DWL_W-1:0]  DWL_LOAD   = DWL_W'(MIN_DWELL);
    localparam logic [WIN_W-1:0]  WIN_LAST   = WIN_W'(WIN_LEN - 1);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_SWAP  = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [MODE_W-1:0] mode_n, target, target_n;
    logic [DRN_W-1:0]  drain_cnt, drain_n;
    logic [DWL_W-1:0]  dwell, dwell_n;
    logic [WIN_W-1:0]  win_cnt, win_n;
    logic [ACT_W-1:0]  act_cnt, act_n, act_total;
    logic [CNT_W-1:0]  count_n;
    logic              done_n, err_n;
    logic              auto_req;
    logic [MODE_W-1:0] auto_mode;

    always_comb begin
        state_n   = state;
        mode_n    = active_mode;
        target_n  = target;
        drain_n   = drain_cnt;
        dwell_n   = dwell;
        win_n     = win_cnt;
        act_n     = act_cnt;
        count_n   = switch_count;
        done_n    = 1'b0;
        err_n     = 1'b0;
        auto_req  = 1'b0;
        auto_mode = active_mode;
        req_ready = (state == S_RUN) && (dwell == '0);
        // Activity including the current cycle, so the decision sees the full window.
        act_total = act_cnt + {{(ACT_W - 1){1'b0}}, valid};

        case (state)
            S_RUN: begin
                if (dwell != '0) begin
                    dwell_n = dwell - DWL_W'(1);
                end
                if (auto_en) begin
                    if (win_cnt == WIN_LAST) begin
                        win_n = '0;
                        act_n = '0;
                        if (int'(act_total) >= UP_THRESH && active_mode < TOP_MODE) begin
                            auto_req  = 1'b1;
                            auto_mode = active_mode + MODE_W'(1);
                        end else if (int'(act_total) <= DOWN_THRESH && active_mode != '0) begin
                            auto_req  = 1'b1;
                            auto_mode = active_mode - MODE_W'(1);
                        end
                    end else begin
                        win_n = win_cnt + WIN_W'(1);
                        act_n = act_total;
                    end
                end else begin
                    win_n = '0;
                    act_n = '0;
                end
                // A taken manual request (even a no-op or an error) swallows the auto decision.
                if (req_valid && req_ready) begin
                    if ({1'b0, req_mode} >= MODE_LIMIT) begin
                        err_n = 1'b1;
                    end else if (req_mode != active_mode) begin
                        target_n = req_mode;
                        drain_n  = DRN_LOAD;
                        state_n  = S_DRAIN;
                    end
                end else if (auto_req && req_ready) begin
                    target_n = auto_mode;
                    drain_n  = DRN_LOAD;
                    state_n  = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_cnt == '0) begin
                    state_n = S_SWAP;
                end else begin
                    drain_n = drain_cnt - DRN_W'(1);
                end
            end
            S_SWAP: begin
                state_n = S_RUN;
                mode_n  = target;
                if (switch_count != '1) begin
                    count_n = switch_count + CNT_W'(1);
                end
                dwell_n = DWL_LOAD;
                win_n   = '0;
                act_n   = '0;
                done_n  = 1'b1;
            end
            default: state_n = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_RUN;
            active_mode  <= RST_MODE;
            target       <= RST_MODE;
            drain_cnt    <= '0;
            dwell        <= '0;
            win_cnt      <= '0;
            act_cnt      <= '0;
            switch_count <= '0;
            issue_stall  <= 1'b0;
            switching    <= 1'b0;
            switch_done  <= 1'b0;
            req_err      <= 1'b0;
        end else begin
            state        <= state_n;
            active_mode  <= mode_n;
            target       <= target_n;
            drain_cnt    <= drain_n;
            dwell        <= dwell_n;
            win_cnt      <= win_n;
            act_cnt      <= act_n;
            switch_count <= count_n;
            issue_stall  <= (state_n != S_RUN);
            switching    <= (state_n != S_RUN);
            switch_done  <= done_n;
            req_err      <= err_n;
        end
    end

    always_comb begin
        mode_onehot = '0;
        for (int i = 0; i < NUM_MODES; i++) begin
            mode_onehot[i] = (active_mode == MODE_W'(i));
        end
    end

endmodule

// File: tb/tb_adaptive_mode_sequencer.sv
// tb/tb_adaptive_mode_sequencer.sv - bench for adaptive_mode_sequencer
module tb_adaptive_mode_sequencer;

    localparam int N       = 4;
    localparam int DRAIN   = 3;
    localparam int DWELL   = 16;
    localparam int WIN     = 64;
    localparam int UP      = 48;
    localparam int DOWN    = 8;
    localparam int CNT_MAX = 65535;

    logic        clk = 1'b0;
    logic        rst, valid, req_valid, auto_en;
    logic [1:0]  req_mode;
    logic        req_ready, issue_stall, switching, switch_done, req_err;
    logic [1:0]  active_mode;
    logic [3:0]  mode_onehot;
    logic [15:0] switch_count;

    logic        b_rst, b_req_valid;
    logic [2:0]  b_req_mode;
    logic        b_req_ready, b_issue_stall, b_switching, b_switch_done, b_req_err;
    logic [2:0]  b_active_mode;
    logic [4:0]  b_mode_onehot;
    logic [7:0]  b_switch_count;

    int checks = 0;
    int failures = 0;

    int m_mode, m_stall, m_target, m_dwell, m_win, m_act, m_cnt;
    bit m_done, m_err;

    always #5 clk = ~clk;

    adaptive_mode_sequencer dut (
        .clk(clk), .rst(rst), .valid(valid), .req_valid(req_valid), .req_mode(req_mode),
        .auto_en(auto_en), .req_ready(req_ready), .active_mode(active_mode),
        .mode_onehot(mode_onehot), .issue_stall(issue_stall), .switching(switching),
        .switch_done(switch_done), .req_err(req_err), .switch_count(switch_count)
    );

    adaptive_mode_sequencer #(
        .NUM_MODES(5), .RESET_MODE(0), .DRAIN_CYCLES(1), .MIN_DWELL(2),
        .WIN_LEN(8), .UP_THRESH(6), .DOWN_THRESH(1), .CNT_W(8)
    ) dut_b (
        .clk(clk), .rst(b_rst), .valid(1'b0), .req_valid(b_req_valid), .req_mode(b_req_mode),
        .auto_en(1'b0), .req_ready(b_req_ready), .active_mode(b_active_mode),
        .mode_onehot(b_mode_onehot), .issue_stall(b_issue_stall), .switching(b_switching),
        .switch_done(b_switch_done), .req_err(b_req_err), .switch_count(b_switch_count)
    );

    // Reference: a switch is a single stall budget of DRAIN+1 cycles ending in the mode change.
    task automatic model_edge();
        int tot, auto_tgt;
        bit ready, auto_req;
        m_done = 0;
        m_err  = 0;
        if (rst) begin
            m_mode = 0; m_stall = 0; m_dwell = 0; m_win = 0; m_act = 0; m_cnt = 0;
            return;
        end
        if (m_stall > 0) begin
            m_stall--;
            if (m_stall == 0) begin
                m_mode = m_target;
                if (m_cnt < CNT_MAX) m_cnt++;
                m_dwell = DWELL; m_win = 0; m_act = 0; m_done = 1;
            end
            return;
        end
        ready = (m_dwell == 0);
        if (m_dwell > 0) m_dwell--;
        auto_req = 0;
        auto_tgt = m_mode;
        if (auto_en) begin
            tot = m_act + int'(valid);
            if (m_win == WIN - 1) begin
                if (tot >= UP && m_mode < N - 1) begin auto_req = 1; auto_tgt = m_mode + 1; end
                else if (tot <= DOWN && m_mode > 0) begin auto_req = 1; auto_tgt = m_mode - 1; end
                m_win = 0; m_act = 0;
            end else begin
                m_win++; m_act = tot;
            end
        end else begin
            m_win = 0; m_act = 0;
        end
        if (req_valid && ready) begin
            if (int'(req_mode) >= N) m_err = 1;
            else if (int'(req_mode) != m_mode) begin m_target = req_mode; m_stall = DRAIN + 1; end
        end else if (auto_req && ready) begin
            m_target = auto_tgt; m_stall = DRAIN + 1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1; b_rst = 1;
        step();
        rst = 0; b_rst = 0;
    endtask

    task automatic test_reset();
        req_valid = 0; req_mode = 0; auto_en = 0; valid = 0;
        b_req_valid = 0; b_req_mode = 0;
        do_reset();
        checks++; if (active_mode !== 2'd0) begin failures++; $display("FAIL reset_mode got %0d want 0", active_mode); end
        checks++; if (mode_onehot !== 4'b0001) begin failures++; $display("FAIL reset_onehot got %b want 0001", mode_onehot); end
        checks++; if ({issue_stall, switching, switch_done, req_err} !== 4'b0000) begin failures++; $display("FAIL reset_flags got %b want 0000", {issue_stall, switching, switch_done, req_err}); end
        checks++; if (switch_count !== 16'd0) begin failures++; $display("FAIL reset_count got %0d want 0", switch_count); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got %b want 1", req_ready); end
    endtask

    task automatic test_switch();
        req_valid = 1; req_mode = 2;
        step();
        req_valid = 0;
        for (int k = 0; k < DRAIN + 1; k++) begin
            checks++; if (issue_stall !== 1'b1 || switching !== 1'b1 || req_ready !== 1'b0 || active_mode !== 2'd0) begin
                failures++; $display("FAIL switch_stall cyc %0d got stall=%b sw=%b rdy=%b mode=%0d want 1 1 0 0", k, issue_stall, switching, req_ready, active_mode);
            end
            step();
        end
        checks++; if (issue_stall !== 1'b0 || active_mode !== 2'd2 || switch_done !== 1'b1) begin
            failures++; $display("FAIL switch_done got stall=%b mode=%0d done=%b want 0 2 1", issue_stall, active_mode, switch_done);
        end
        checks++; if (switch_count !== 16'd1 || mode_onehot !== 4'b0100) begin
            failures++; $display("FAIL switch_count got cnt=%0d oh=%b want 1 0100", switch_count, mode_onehot);
        end
    endtask

    task automatic test_dwell();
        req_valid = 1; req_mode = 1;
        for (int k = 0; k < DWELL; k++) begin
            checks++; if (req_ready !== 1'b0 || issue_stall !== 1'b0) begin
                failures++; $display("FAIL dwell_block cyc %0d got rdy=%b stall=%b want 0 0", k, req_ready, issue_stall);
            end
            step();
        end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL dwell_release got rdy=%b want 1", req_ready); end
        step();
        req_valid = 0;
        checks++; if (issue_stall !== 1'b1) begin failures++; $display("FAIL dwell_accept got stall=%b want 1", issue_stall); end
        repeat (DRAIN + 1) step();
        checks++; if (active_mode !== 2'd1 || switch_count !== 16'd2) begin
            failures++; $display("FAIL dwell_switch got mode=%0d cnt=%0d want 1 2", active_mode, switch_count);
        end
    endtask

    task automatic test_noop();
        int n = 0;
        while (req_ready !== 1'b1 && n < 40) begin step(); n++; end
        checks++; if (n != DWELL) begin failures++; $display("FAIL noop_wait got %0d cycles want %0d", n, DWELL); end
        req_valid = 1; req_mode = 1;
        step();
        req_valid = 0;
        for (int k = 0; k < 3; k++) begin
            checks++; if (issue_stall !== 1'b0 || switch_count !== 16'd2 || req_ready !== 1'b1 || switch_done !== 1'b0) begin
                failures++; $display("FAIL noop cyc %0d got stall=%b cnt=%0d rdy=%b done=%b want 0 2 1 0", k, issue_stall, switch_count, req_ready, switch_done);
            end
            step();
        end
    endtask

    task automatic test_req_err();
        b_req_valid = 1; b_req_mode = 6;
        step();
        b_req_valid = 0;
        checks++; if (b_req_err !== 1'b1 || b_issue_stall !== 1'b0 || b_active_mode !== 3'd0 || b_switch_count !== 8'd0 || b_req_ready !== 1'b1) begin
            failures++; $display("FAIL err_pulse got err=%b stall=%b mode=%0d cnt=%0d rdy=%b want 1 0 0 0 1", b_req_err, b_issue_stall, b_active_mode, b_switch_count, b_req_ready);
        end
        step();
        checks++; if (b_req_err !== 1'b0) begin failures++; $display("FAIL err_one_cycle got %b want 0", b_req_err); end
        b_req_valid = 1; b_req_mode = 4;
        step();
        b_req_valid = 0;
        checks++; if (b_issue_stall !== 1'b1) begin failures++; $display("FAIL b_top_stall got %b want 1", b_issue_stall); end
        step(); step();
        checks++; if (b_active_mode !== 3'd4 || b_mode_onehot !== 5'b10000 || b_switch_done !== 1'b1 || b_req_ready !== 1'b0) begin
            failures++; $display("FAIL b_top_mode got mode=%0d oh=%b done=%b rdy=%b want 4 10000 1 0", b_active_mode, b_mode_onehot, b_switch_done, b_req_ready);
        end
        b_req_valid = 1; b_req_mode = 7;
        step(); step();
        checks++; if (b_req_err !== 1'b0 || b_req_ready !== 1'b1) begin
            failures++; $display("FAIL b_err_dwell got err=%b rdy=%b want 0 1", b_req_err, b_req_ready);
        end
        step();
        b_req_valid = 0;
        checks++; if (b_req_err !== 1'b1 || b_active_mode !== 3'd4 || b_switch_count !== 8'd1) begin
            failures++; $display("FAIL b_err_late got err=%b mode=%0d cnt=%0d want 1 4 1", b_req_err, b_active_mode, b_switch_count);
        end
    endtask

    task automatic test_auto();
        int changes[$];
        int prev, n;
        do_reset();
        auto_en = 1; valid = 1;
        prev = 0; n = 0;
        for (int k = 1; k <= 300; k++) begin
            step();
            if (int'(active_mode) != prev) begin
                checks++; if (int'(active_mode) != prev + 1) begin failures++; $display("FAIL auto_up_step got %0d want %0d", active_mode, prev + 1); end
                changes.push_back(k);
                prev = active_mode;
            end
        end
        checks++; if (changes.size() != 3 || active_mode !== 2'd3) begin
            failures++; $display("FAIL auto_up got changes=%0d mode=%0d want 3 3", changes.size(), active_mode);
        end
        for (int i = 0; i < changes.size() && i < 3; i++) begin
            checks++; if (changes[i] != 68 * (i + 1)) begin
                failures++; $display("FAIL auto_up_time %0d got %0d want %0d", i, changes[i], 68 * (i + 1));
            end
        end
        valid = 0;
        changes.delete();
        for (int k = 1; k <= 300; k++) begin
            step();
            if (int'(active_mode) != prev) begin
                checks++; if (int'(active_mode) != prev - 1) begin failures++; $display("FAIL auto_down_step got %0d want %0d", active_mode, prev - 1); end
                changes.push_back(k);
                prev = active_mode;
            end
        end
        checks++; if (changes.size() != 3 || active_mode !== 2'd0 || switch_count !== 16'd6) begin
            failures++; $display("FAIL auto_down got changes=%0d mode=%0d cnt=%0d want 3 0 6", changes.size(), active_mode, switch_count);
        end
        if (changes.size() == 3) begin
            checks++; if (changes[1] - changes[0] != 68 || changes[2] - changes[1] != 68) begin
                failures++; $display("FAIL auto_down_spacing got %0d %0d want 68 68", changes[1] - changes[0], changes[2] - changes[1]);
            end
        end
        auto_en = 0;
    endtask

    task automatic test_conflict();
        do_reset();
        auto_en = 1; valid = 1;
        repeat (68) step();
        checks++; if (active_mode !== 2'd1) begin failures++; $display("FAIL conflict_setup got %0d want 1", active_mode); end
        repeat (63) step();
        req_valid = 1; req_mode = 0;
        step();
        req_valid = 0;
        repeat (DRAIN + 1) step();
        checks++; if (active_mode !== 2'd0 || switch_count !== 16'd2 || switch_done !== 1'b1) begin
            failures++; $display("FAIL conflict got mode=%0d cnt=%0d done=%b want 0 2 1", active_mode, switch_count, switch_done);
        end
        auto_en = 0; valid = 0;
    endtask

    task automatic test_reset_mid();
        repeat (DWELL) step();
        req_valid = 1; req_mode = 3;
        step();
        req_valid = 0;
        step();
        checks++; if (issue_stall !== 1'b1) begin failures++; $display("FAIL mid_drain got stall=%b want 1", issue_stall); end
        rst = 1; step(); rst = 0;
        checks++; if (active_mode !== 2'd0 || issue_stall !== 1'b0 || switching !== 1'b0 || switch_count !== 16'd0 || req_ready !== 1'b1) begin
            failures++; $display("FAIL mid_reset got mode=%0d stall=%b sw=%b cnt=%0d rdy=%b want 0 0 0 0 1", active_mode, issue_stall, switching, switch_count, req_ready);
        end
        repeat (6) step();
        checks++; if (active_mode !== 2'd0 || switch_done !== 1'b0) begin
            failures++; $display("FAIL mid_reset_after got mode=%0d done=%b want 0 0", active_mode, switch_done);
        end
    endtask

    task automatic test_random();
        int pct = 50;
        for (int k = 0; k < 4000; k++) begin
            if (k % 250 == 0) begin
                pct = (($urandom_range(0, 4)) * 25);
                auto_en = ($urandom_range(0, 3) != 0);
            end
            rst       = ($urandom_range(0, 299) == 0);
            valid     = ($urandom_range(1, 100) <= pct);
            req_valid = ($urandom_range(0, 19) == 0);
            req_mode  = 2'($urandom_range(0, 3));
            step();
            checks++; if (int'(active_mode) != m_mode || mode_onehot !== 4'(1 << m_mode)) begin
                failures++; $display("FAIL rnd_mode cyc %0d got %0d/%b want %0d", k, active_mode, mode_onehot, m_mode);
            end
            checks++; if (issue_stall !== (m_stall != 0) || switching !== (m_stall != 0)) begin
                failures++; $display("FAIL rnd_stall cyc %0d got %b/%b want %b", k, issue_stall, switching, m_stall != 0);
            end
            checks++; if (switch_done !== m_done || req_err !== m_err) begin
                failures++; $display("FAIL rnd_pulse cyc %0d got done=%b err=%b want %b %b", k, switch_done, req_err, m_done, m_err);
            end
            checks++; if (int'(switch_count) != m_cnt) begin
                failures++; $display("FAIL rnd_count cyc %0d got %0d want %0d", k, switch_count, m_cnt);
            end
            checks++; if (req_ready !== (m_stall == 0 && m_dwell == 0)) begin
                failures++; $display("FAIL rnd_ready cyc %0d got %b want %b", k, req_ready, m_stall == 0 && m_dwell == 0);
            end
        end
        rst = 0; req_valid = 0; auto_en = 0; valid = 0;
    endtask

    initial begin
        rst = 1; b_rst = 1; valid = 0; req_valid = 0; req_mode = 0; auto_en = 0;
        b_req_valid = 0; b_req_mode = 0;
        m_mode = 0; m_stall = 0; m_target = 0; m_dwell = 0; m_win = 0; m_act = 0; m_cnt = 0;
        m_done = 0; m_err = 0;
        #2;
        test_reset();
        test_switch();
        test_dwell();
        test_noop();
        test_req_err();
        test_auto();
        test_conflict();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
